// File: rtl/mano_pkg.sv
// ---------------------------------------------------------------------------
// mano_pkg
//   Shared definitions for the basic computer's accumulator datapath and the
//   control unit's decoder.
//   - AC_WIDTH / INPR_WIDTH : default datapath and input-character widths.
//   - OP_* : bit index of each AC operation inside the one-hot select
//            vector. Lower index means higher priority.
//   - ac_sel_t : one-hot AC-operation select.
//   - pri_select() : keeps only the highest-priority (lowest index) request.
// ---------------------------------------------------------------------------
package mano_pkg;

    localparam int AC_WIDTH   = 16;
    localparam int INPR_WIDTH = 8;

    localparam int OP_CLA = 0;
    localparam int OP_AND = 1;
    localparam int OP_ADD = 2;
    localparam int OP_LDA = 3;
    localparam int OP_INP = 4;
    localparam int OP_CMA = 5;
    localparam int OP_CIR = 6;
    localparam int OP_CIL = 7;
    localparam int OP_INC = 8;
    localparam int OP_NUM = 9;

    typedef logic [OP_NUM-1:0] ac_sel_t;

    // Isolate the lowest set bit: the request with the highest priority wins.
    function automatic ac_sel_t pri_select(input ac_sel_t raw);
        return raw & (~raw + ac_sel_t'(1));
    endfunction

endpackage

// File: rtl/alu_logic.sv
// ---------------------------------------------------------------------------
// alu_logic
//   Purely combinational adder-and-logic circuit for the accumulator.
//   Ports:
//     ac      in   WIDTH     current accumulator
//     dr      in   WIDTH     data register operand
//     inpr    in   IN_WIDTH  input character
//     e       in   1         current E flip-flop
//     sel     in   OP_NUM    one-hot AC-operation select (all zero = hold)
//     next_ac out  WIDTH     accumulator result
//     next_e  out  1         E result (meaningful when e_write is set)
//     e_write out  1         selected operation produces a new E value
// ---------------------------------------------------------------------------
module alu_logic
    import mano_pkg::*;
#(
    parameter int WIDTH    = AC_WIDTH,
    parameter int IN_WIDTH = INPR_WIDTH
) (
    input  logic [WIDTH-1:0]    ac,
    input  logic [WIDTH-1:0]    dr,
    input  logic [IN_WIDTH-1:0] inpr,
    input  logic                e,
    input  ac_sel_t             sel,
    output logic [WIDTH-1:0]    next_ac,
    output logic                next_e,
    output logic                e_write
);

    // Bits of AC replaced by INP; the upper bits are kept.
    localparam logic [WIDTH-1:0] INP_MASK = WIDTH'({IN_WIDTH{1'b1}});

    logic [WIDTH:0] sum;

    // Extra MSB captures the carry out for E.
    assign sum = {1'b0, ac} + {1'b0, dr};

    always_comb begin
        next_ac = ac;
        next_e  = e;
        e_write = 1'b0;
        if (sel[OP_CLA]) begin
            next_ac = '0;
        end else if (sel[OP_AND]) begin
            next_ac = ac & dr;
        end else if (sel[OP_ADD]) begin
            next_ac = sum[WIDTH-1:0];
            next_e  = sum[WIDTH];
            e_write = 1'b1;
        end else if (sel[OP_LDA]) begin
            next_ac = dr;
        end else if (sel[OP_INP]) begin
            next_ac = (ac & ~INP_MASK) | WIDTH'(inpr);
        end else if (sel[OP_CMA]) begin
            next_ac = ~ac;
        end else if (sel[OP_CIR]) begin
            next_ac = {e, ac[WIDTH-1:1]};
            next_e  = ac[0];
            e_write = 1'b1;
        end else if (sel[OP_CIL]) begin
            next_ac = {ac[WIDTH-2:0], e};
            next_e  = ac[WIDTH-1];
            e_write = 1'b1;
        end else if (sel[OP_INC]) begin
            // Carry is discarded; E is untouched.
            next_ac = ac + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ac_alu.sv
// ---------------------------------------------------------------------------
// ac_alu
//   Accumulator AC, carry/link flip-flop E and their update logic.
//   Ports:
//     CLK      in   1         clock, updates on rising edge
//     CLR      in   1         asynchronous active-high reset (AC=0, E=0)
//     inDR     in   WIDTH     DR output
//     inINPR   in   IN_WIDTH  input character
//     CLA..INC in   1 each    AC operations, priority CLA>AND>ADD>LDA>INP>
//                             CMA>CIR>CIL>INC
//     CLE,CME  in   1 each    E clear / complement (CLE wins)
//     AC       out  WIDTH     accumulator
//     E        out  1         carry/link
//     AC_ZERO  out  1         AC == 0
//     AC_NEG   out  1         AC sign bit
// ---------------------------------------------------------------------------
module ac_alu
    import mano_pkg::*;
#(
    parameter int WIDTH    = AC_WIDTH,
    parameter int IN_WIDTH = INPR_WIDTH
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [WIDTH-1:0]    inDR,
    input  logic [IN_WIDTH-1:0] inINPR,
    input  logic                CLA,
    input  logic                AND,
    input  logic                ADD,
    input  logic                LDA,
    input  logic                INP,
    input  logic                CMA,
    input  logic                CIR,
    input  logic                CIL,
    input  logic                INC,
    input  logic                CLE,
    input  logic                CME,
    output logic [WIDTH-1:0]    AC,
    output logic                E,
    output logic                AC_ZERO,
    output logic                AC_NEG
);

    if (IN_WIDTH > WIDTH) begin : g_width_check
        $error("ac_alu: IN_WIDTH must not exceed WIDTH");
    end

    logic [WIDTH-1:0] ac_p0;
    logic             e_p0;
    ac_sel_t          req;
    ac_sel_t          sel;
    logic             ac_load;
    logic [WIDTH-1:0] next_ac;
    logic             next_e;
    logic             e_write;

    // Requests packed so that bit index equals priority rank.
    assign req = {INC, CIL, CIR, CMA, INP, LDA, ADD, AND, CLA};
    assign sel = pri_select(req);
    assign ac_load = |sel;

    alu_logic #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH)
    ) u_alu_logic (
        .ac      (ac_p0),
        .dr      (inDR),
        .inpr    (inINPR),
        .e       (e_p0),
        .sel     (sel),
        .next_ac (next_ac),
        .next_e  (next_e),
        .e_write (e_write)
    );

    // ---- stage p0: AC / E registers ----
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ac_p0 <= '0;
            e_p0  <= 1'b0;
        end else begin
            if (ac_load) begin
                ac_p0 <= next_ac;
            end
            // A carry-producing AC operation owns E that cycle.
            if (e_write) begin
                e_p0 <= next_e;
            end else if (CLE) begin
                e_p0 <= 1'b0;
            end else if (CME) begin
                e_p0 <= ~e_p0;
            end
        end
    end

    assign AC      = ac_p0;
    assign E       = e_p0;
    assign AC_ZERO = (ac_p0 == '0);
    assign AC_NEG  = ac_p0[WIDTH-1];

endmodule

// File: doc/ac_alu.md
Name: ac_alu

Overview:
- Accumulator (AC), the E carry/link flip-flop, and the adder-and-logic circuit of the basic computer.
- Sits directly downstream of the data register: consumes DR's 16-bit output and the 8-bit INPR character.
- Updates AC/E on the rising clock edge under control-unit decode signals.
- Exports AC and the status flags used by SZA/SNA/SZE skip logic and by the common bus.

Parameters:
- WIDTH, 16, data path width of AC, DR input and adder.
- IN_WIDTH, 8, INPR width; must be less than or equal to WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  asynchronous, active-high reset.
- inDR  input  WIDTH  DR register output (operand for AND/ADD/LDA).
- inINPR  input  IN_WIDTH  input register character.
- CLA  input  1  clear AC.
- AND  input  1  AC <= AC & DR.
- ADD  input  1  {E,AC} <= AC + DR.
- LDA  input  1  AC <= DR.
- INP  input  1  AC[IN_WIDTH-1:0] <= INPR.
- CMA  input  1  AC <= ~AC.
- CIR  input  1  circulate right through E.
- CIL  input  1  circulate left through E.
- INC  input  1  AC <= AC + 1.
- CLE  input  1  E <= 0.
- CME  input  1  E <= ~E.
- AC  output  WIDTH  accumulator value.
- E  output  1  carry/link flip-flop.
- AC_ZERO  output  1  1 when AC == 0 (SZA).
- AC_NEG  output  1  AC[WIDTH-1] (SNA).

Behaviour:
- Reset: CLR high asynchronously forces AC=0 and E=0, independent of CLK and of all controls. While CLR is high, no control has effect. First update occurs on the first rising CLK after CLR falls.
- Latency: one cycle. The control pulse sampled at edge n gives the new AC/E visible after edge n. AC_ZERO and AC_NEG are combinational from the registered AC, so they are valid in the same cycle as AC.
- No control asserted: AC and E hold.
- AC operation priority when several are asserted at once (control decode should never do this; the block must still be deterministic): CLA > AND > ADD > LDA > INP > CMA > CIR > CIL > INC. Exactly one AC operation executes per edge.
- ADD: WIDTH+1-bit sum of AC and inDR. AC <= sum[WIDTH-1:0], E <= sum[WIDTH] (carry out). Wrap-around is natural.
- INC: AC <= AC + 1 modulo 2^WIDTH. 16'hFFFF goes to 16'h0000. E is unchanged; carry is discarded.
- CIR: AC <= {E, AC[WIDTH-1:1]}, E <= AC[0].
- CIL: AC <= {AC[WIDTH-2:0], E}, E <= AC[WIDTH-1].
- INP: AC lower IN_WIDTH bits <= inINPR; upper bits unchanged.
- AND, LDA, CMA, CLA: E unchanged.
- E write priority: if the winning AC operation is ADD, CIR or CIL, its E result wins. Otherwise CLE > CME. CLE and CME may combine with a non-E AC operation in the same cycle (e.g. CLA+CLE both take effect).
- Reset mid-operation: an asserted CLR during a control pulse discards that operation; AC=0 and E=0 result.

Decomposition:
- Shared package (mano_pkg): WIDTH/IN_WIDTH constants and the AC-operation select encoding (one-hot index constants in the priority order above). The control unit's decoder uses the same package.
- One natural sub-module: alu_logic, purely combinational. Inputs: AC, DR, INPR, E, select. Outputs: next_AC, next_E, e_write. The ac_alu top holds only the AC/E registers, the priority encoder, and the flags.

Test Plan:
- Reset: preload AC=16'h1234 and E=1 via LDA/CME, then pulse CLR between edges -> AC=0 and E=0 immediately, before the next CLK; AC_ZERO=1.
- ADD carry: AC=16'hFFFF, inDR=16'h0002, ADD -> AC=16'h0001, E=1. Then inDR=16'h7FFF, ADD -> AC=16'h8000, E=0, AC_NEG=1.
- Circulate: AC=16'h8001, E=0. CIL -> AC=16'h0002, E=1. CIR -> AC=16'h8001, E=0.
- INC wrap and INP: AC=16'hFFFF, E=1, INC -> AC=16'h0000, E=1, AC_ZERO=1. Then inINPR=8'hA5, INP -> AC=16'h00A5.
- Logic ops: AC=16'hF0F0, inDR=16'h0FF0, AND -> AC=16'h00F0. CMA -> AC=16'hFF0F.
- Simultaneous controls: CLA+ADD+CME with E=0 -> AC=0, E=1. ADD+CLE with AC=16'hFFFF, inDR=1 -> AC=0, E=1 (ADD wins E).
